// File: rtl/dram_emu_ctrl.sv
`default_nettype none
// ============================================================================
// dram_emu_ctrl : multiplexed-address DRAM emulation held in block RAM, with a
//                 download write port for ROM/program images.
// Revision      : 1.0 - initial release
// ============================================================================
module dram_emu_ctrl #(
    parameter int          MUX_WIDTH   = 8,
    parameter int          DATA_WIDTH  = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned DL_BASE     = 32'h0000_C000,
    parameter int          DL_WIDTH    = 14
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [MUX_WIDTH-1:0]  ma,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  d_oe,
    input  logic                  dl_download,
    input  logic                  dl_wr,
    input  logic [26:0]           dl_addr,
    input  logic [7:0]            dl_data,
    output logic [15:0]           ref_cnt,
    output logic                  page_hit
);

    localparam int c_AW    = 2 * MUX_WIDTH;
    localparam int c_SW    = 3 + MUX_WIDTH + DATA_WIDTH;
    localparam int c_DEPTH = 1 << c_AW;
    localparam logic [c_SW-1:0] c_SYNC_RST = {3'b111, {(MUX_WIDTH + DATA_WIDTH){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ROW_OPEN   = 3'd1,
        S_COL_ACCESS = 3'd2,
        S_CBR_ARMED  = 3'd3,
        S_CBR_HOLD   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Synchroniser: strobes, address and data travel as one word so they stay
    // aligned with each other through every stage.
    // ------------------------------------------------------------------------
    logic [c_SW-1:0]        r_sync [SYNC_STAGES];
    logic [2:0]             r_strb_prev;
    logic [SYNC_STAGES-1:0] r_flush;
    logic [2:0]             r_arm;

    logic [2:0]             w_strb;
    logic                   w_ras_s;
    logic                   w_cas_s;
    logic                   w_we_s;
    logic [MUX_WIDTH-1:0]   w_ma_s;
    logic [DATA_WIDTH-1:0]  w_d_s;
    logic                   w_live;
    logic                   w_ras_fall;
    logic                   w_ras_rise;
    logic                   w_cas_fall;
    logic                   w_cas_rise;
    logic                   w_we_fall;

    assign w_strb  = r_sync[SYNC_STAGES-1][c_SW-1 -: 3];
    assign w_ras_s = w_strb[2];
    assign w_cas_s = w_strb[1];
    assign w_we_s  = w_strb[0];
    assign w_ma_s  = r_sync[SYNC_STAGES-1][DATA_WIDTH +: MUX_WIDTH];
    assign w_d_s   = r_sync[SYNC_STAGES-1][DATA_WIDTH-1:0];
    assign w_live  = r_flush[SYNC_STAGES-1];

    // A falling edge counts only once that strobe has been seen high after reset
    assign w_ras_fall = r_arm[2] & r_strb_prev[2] & ~w_ras_s;
    assign w_cas_fall = r_arm[1] & r_strb_prev[1] & ~w_cas_s;
    assign w_we_fall  = r_arm[0] & r_strb_prev[0] & ~w_we_s;
    assign w_ras_rise = w_live & ~r_strb_prev[2] & w_ras_s;
    assign w_cas_rise = w_live & ~r_strb_prev[1] & w_cas_s;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= c_SYNC_RST;
            end
            r_strb_prev <= 3'b111;
            r_flush     <= '0;
            r_arm       <= 3'b000;
        end else begin
            r_sync[0] <= {ras_n, cas_n, we_n, ma, d_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_strb_prev <= w_strb;
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_arm       <= w_live ? (r_arm | w_strb) : 3'b000;
        end
    end

    // ------------------------------------------------------------------------
    // Access state machine
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [MUX_WIDTH-1:0]  r_row;
    logic [MUX_WIDTH-1:0]  w_row_nxt;
    logic [MUX_WIDTH-1:0]  r_col;
    logic [MUX_WIDTH-1:0]  w_col_nxt;
    logic                  r_cas_seen;
    logic                  w_cas_seen_nxt;
    logic                  r_is_read;
    logic                  w_is_read_nxt;
    logic                  r_wr_done;
    logic                  w_wr_done_nxt;
    logic                  r_d_oe;
    logic                  w_d_oe_nxt;
    logic                  r_page_hit;
    logic                  w_page_hit_nxt;
    logic [DATA_WIDTH-1:0] r_d_out;
    logic [15:0]           r_ref_cnt;
    logic                  w_ref_inc;
    logic                  w_rd_en;
    logic                  w_mwr_req;
    logic                  w_mwr_en;
    logic [c_AW-1:0]       w_acc_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_cas_seen_nxt = r_cas_seen;
        w_is_read_nxt  = r_is_read;
        w_wr_done_nxt  = r_wr_done;
        w_d_oe_nxt     = r_d_oe;
        w_page_hit_nxt = 1'b0;
        w_ref_inc      = 1'b0;
        w_rd_en        = 1'b0;
        w_mwr_req      = 1'b0;
        w_acc_addr     = {r_row, r_col};

        case (r_state)
            S_IDLE: begin
                // Coincident RAS/CAS falls open the row but the CAS edge is consumed
                if (w_ras_fall && (w_cas_s || w_cas_fall)) begin
                    w_row_nxt      = w_ma_s;
                    w_cas_seen_nxt = w_cas_fall;
                    w_state_nxt    = S_ROW_OPEN;
                end else if (w_cas_fall && w_ras_s) begin
                    w_state_nxt = S_CBR_ARMED;
                end
            end
            S_ROW_OPEN: begin
                if (w_ras_rise) begin
                    w_ref_inc   = ~r_cas_seen;
                    w_state_nxt = S_IDLE;
                end else if (w_cas_fall) begin
                    w_col_nxt      = w_ma_s;
                    w_acc_addr     = {r_row, w_ma_s};
                    w_page_hit_nxt = r_cas_seen;
                    w_cas_seen_nxt = 1'b1;
                    w_state_nxt    = S_COL_ACCESS;
                    if (w_we_s) begin
                        w_rd_en       = 1'b1;
                        w_d_oe_nxt    = 1'b1;
                        w_is_read_nxt = 1'b1;
                        w_wr_done_nxt = 1'b0;
                    end else begin
                        w_mwr_req     = 1'b1;
                        w_is_read_nxt = 1'b0;
                        w_wr_done_nxt = 1'b1;
                    end
                end
            end
            S_COL_ACCESS: begin
                if (w_cas_rise) begin
                    w_d_oe_nxt  = 1'b0;
                    w_state_nxt = w_ras_s ? S_IDLE : S_ROW_OPEN;
                end else if (w_we_fall && r_is_read && !r_wr_done) begin
                    w_d_oe_nxt    = 1'b0;
                    w_mwr_req     = 1'b1;
                    w_wr_done_nxt = 1'b1;
                end
            end
            S_CBR_ARMED: begin
                if (w_ras_fall) begin
                    w_ref_inc   = 1'b1;
                    w_state_nxt = S_CBR_HOLD;
                end else if (w_cas_rise) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CBR_HOLD: begin
                if (w_ras_s && w_cas_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_mwr_en = w_mwr_req & ~dl_download;

    // ------------------------------------------------------------------------
    // Storage: machine port (read/write) and download port (write only)
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_AW-1:0]       w_dl_addr;
    logic                  w_unused;

    assign w_dl_addr = c_AW'(DL_BASE) + c_AW'(dl_addr[DL_WIDTH-1:0]);
    assign w_unused  = &{1'b0, dl_addr[26:DL_WIDTH]};

    always_ff @(posedge clk_sys) begin
        if (w_mwr_en) begin
            r_mem[w_acc_addr] <= w_d_s;
        end
        if (dl_wr && dl_download) begin
            r_mem[w_dl_addr] <= DATA_WIDTH'(dl_data);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_cas_seen <= 1'b0;
            r_is_read  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_d_oe     <= 1'b0;
            r_page_hit <= 1'b0;
            r_d_out    <= '0;
            r_ref_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_cas_seen <= w_cas_seen_nxt;
            r_is_read  <= w_is_read_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_d_oe     <= w_d_oe_nxt;
            r_page_hit <= w_page_hit_nxt;
            if (w_rd_en) begin
                r_d_out <= r_mem[w_acc_addr];
            end
            if (w_ref_inc) begin
                r_ref_cnt <= r_ref_cnt + 16'd1;
            end
        end
    end

    assign d_out    = r_d_out;
    assign d_oe     = r_d_oe;
    assign ref_cnt  = r_ref_cnt;
    assign page_hit = r_page_hit;

endmodule
`default_nettype wire

// File: doc/dram_emu_ctrl.md
Name: dram_emu_ctrl

Overview:
Parametrised emulation of a multiplexed-address DRAM array for the Ondra SPO186 core, with the storage held in on-chip block RAM.
- Samples the machine's asynchronous ras_n/cas_n/we_n strobes and multiplexed address in the clk_sys domain.
- Latches row and column, and supports fast page mode, early and late write, and refresh detection.
- Drives a registered data bus toward the machine.
- A second port loads ROM/program images from the HPS download stream at a configurable base address.

Parameters:
MUX_WIDTH, 8, multiplexed address width; memory address is {row, col}, 2*MUX_WIDTH bits.
DATA_WIDTH, 8, data bus width.
SYNC_STAGES, 2, synchroniser depth for strobes, ma, we_n and d_in (minimum 2).
DL_BASE, 16'hC000, memory address of download offset 0.
DL_WIDTH, 14, number of dl_addr bits used; the offset wraps within 2^DL_WIDTH.

Ports:
clk_sys  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
ras_n  in  1  row strobe, asynchronous.
cas_n  in  1  column strobe, asynchronous.
we_n  in  1  write enable, asynchronous.
ma  in  MUX_WIDTH  multiplexed row/column address.
d_in  in  DATA_WIDTH  write data from the machine.
d_out  out  DATA_WIDTH  read data to the machine.
d_oe  out  1  d_out is valid; the top level uses it to drive the shared bus.
dl_download  in  1  download active.
dl_wr  in  1  download byte strobe, one cycle.
dl_addr  in  27  download byte offset.
dl_data  in  8  download byte.
ref_cnt  out  16  refresh event counter; wraps.
page_hit  out  1  one-cycle pulse on each page-mode column access after the first.

Behaviour:
- Reset (asynchronous): state IDLE, d_out=0, d_oe=0, ref_cnt=0, page_hit=0, row/col latches=0, synchroniser chains = inactive strobe levels.
- Synchronisation and edges:
  - ras_n, cas_n, we_n, ma and d_in all pass through SYNC_STAGES flops, so they stay mutually aligned.
  - Edges are detected on the last stage against one extra registered copy.
- ROW state entry:
  - From IDLE, a RAS fall with CAS high latches ma into row and enters ROW_OPEN.
  - A CAS fall while RAS is high enters CBR_ARMED (CAS-before-RAS refresh).
- ROW_OPEN:
  - CAS fall: latch ma into col, go to COL_ACCESS. Second and later CAS falls in the same RAS-low period pulse page_hit.
  - RAS rise with no CAS fall since entry: RAS-only refresh; ref_cnt+1; go to IDLE.
- COL_ACCESS, read (we_n high at CAS fall):
  - Memory read issued in the CAS-fall cycle.
  - d_out is updated and d_oe rises 1 cycle later, i.e. SYNC_STAGES+1 cycles after the raw CAS edge.
  - d_oe and d_out hold until the synchronised CAS rises.
- COL_ACCESS, early write (we_n low at CAS fall): d_in is written to {row,col} in the CAS-fall cycle; d_oe stays 0.
- COL_ACCESS, late write / read-modify-write:
  - we_n falls while in COL_ACCESS after a read: d_oe drops in that cycle.
  - d_in is written in that same cycle using the latched address.
  - Only one write per CAS-low period.
- COL_ACCESS exit on CAS rise:
  - If RAS is still low, go to ROW_OPEN (page mode, row retained).
  - If RAS is high, go to IDLE.
  - d_oe=0 in all exit cases.
- Simultaneous edges:
  - RAS and CAS falling in the same synchronised cycle are treated as RAS first; no access occurs.
  - RAS rising while CAS is low: remain in COL_ACCESS until CAS rises, then go to IDLE.
- CBR_ARMED:
  - RAS fall: ref_cnt+1, go to CBR_HOLD. No memory access; d_oe stays 0.
  - CAS rise with RAS still high: go to IDLE, no count.
- CBR_HOLD: exit to IDLE once both strobes are high.
- Download port:
  - dl_wr & dl_download writes dl_data to DL_BASE + dl_addr[DL_WIDTH-1:0], 2*MUX_WIDTH-bit modulo sum.
  - While dl_download=1, machine writes are suppressed; reads are still served.
  - Download and machine use separate memory ports, so no arbitration is needed otherwise.
- Width rules: DATA_WIDTH is independent of the download port; dl_data is zero-extended or truncated to DATA_WIDTH.
- Reset mid-cycle: returns to IDLE immediately. A strobe already low after reset release is ignored until it has been observed high.
- ref_cnt wraps from 16'hFFFF to 0.

Test Plan:
- Read with MUX_WIDTH=8: preload mem[16'h1234]=8'hA5; RAS fall with ma=8'h12, CAS fall with ma=8'h34, we_n=1 -> d_oe rises 3 cycles after the raw CAS edge with d_out=8'hA5; drops 1 cycle after the synchronised CAS rise.
- Page mode: RAS low on row 8'h40, CAS cycles on cols 8'h00, 8'h01, 8'h02 -> reads mem[16'h4000..16'h4002] in order; page_hit pulses twice; ref_cnt unchanged.
- Early and late write:
  - Early: we_n low at CAS fall, d_in=8'h3C at {8'h10,8'h20} -> mem[16'h1020]=8'h3C; d_oe never asserts.
  - Late: we_n falls mid-CAS with d_in=8'h5A -> d_oe drops; mem holds 8'h5A.
- Refresh: 3 RAS-only cycles then 2 CBR cycles -> ref_cnt=5, no memory change; preset ref_cnt to 16'hFFFF, one more refresh -> ref_cnt=0.
- Download: dl_download=1, dl_wr bytes 8'h11, 8'h22 at dl_addr 0 and 27'h4001 -> mem[16'hC000]=8'h11, mem[16'hC001]=8'h22 (wrap); a concurrent machine write to 16'h0000 is suppressed.
- Asynchronous reset asserted mid-read -> d_oe=0 immediately; with CAS still low after release, no access occurs until CAS goes high and falls again.
